// File: rtl/uba_maint_ctl.sv
// UBA maintenance/control register.
// Holds CTRL_WIDTH read/write control bits, runs the Change Register (CR)
// bit as a timed one-shot (pulse, then holdoff) with a one-deep pending
// queue, and returns a registered read word onto the backplane bus.
module uba_maint_ctl #(
  parameter int CTRL_WIDTH  = 8,
  parameter int PULSE_LEN   = 16,
  parameter int HOLDOFF_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [0:35]           busDATAI,
  input  logic                  maintWRITE,
  input  logic                  maintREAD,
  output logic [0:35]           busDATAO,
  output logic [CTRL_WIDTH-1:0] regCTRL,
  output logic                  maintPULSE,
  output logic                  maintBUSY,
  output logic                  maintDONE
);

  // Bus bit 35 is CR; the control field sits directly above it (bus
  // numbering is big-endian, so "above" means lower bit numbers).
  localparam int FIELD_LO = 35 - CTRL_WIDTH;

  // Counter reload values; the counter counts down to 0 so a phase of
  // length L is loaded with L-1.
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_LEN - 1);
  localparam logic [15:0] HOLD_LOAD  = (HOLDOFF_LEN > 0) ? 16'(HOLDOFF_LEN - 1) : 16'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] count;
  logic [15:0] count_nxt;
  logic        pending;
  logic        pending_nxt;
  logic        done_nxt;
  logic        trigger;
  logic [0:35] read_word;
  logic        unused_bits;

  // CR is a pure trigger: it only acts together with a write strobe.
  assign trigger     = maintWRITE & busDATAI[35];
  assign maintPULSE  = (state == PULSE);
  assign maintBUSY   = (state != IDLE);
  // Bus bits outside the control field and CR carry nothing for this register.
  assign unused_bits = ^busDATAI[0:FIELD_LO-1];

  // Sequencer state, counter, pending flag and DONE strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 16'd0;
      pending   <= 1'b0;
      maintDONE <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      pending   <= pending_nxt;
      maintDONE <= done_nxt;
    end
  end

  // Next-state logic: IDLE -> PULSE -> HOLD -> IDLE, with a one-deep queue
  // for CR triggers that arrive while a sequence is running.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pending_nxt = pending;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (trigger || pending) begin
          state_nxt   = PULSE;
          count_nxt   = PULSE_LOAD;
          pending_nxt = 1'b0;
        end
      end
      PULSE: begin
        if (trigger) pending_nxt = 1'b1;
        if (count != 16'd0) begin
          count_nxt = count - 16'd1;
        end else if (HOLDOFF_LEN == 0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = HOLD;
          count_nxt = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (trigger) pending_nxt = 1'b1;
        if (count != 16'd0) begin
          count_nxt = count - 16'd1;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control bits load from the bus field on every write; CR is not stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regCTRL <= '0;
    end else if (maintWRITE) begin
      regCTRL <= busDATAI[FIELD_LO:34];
    end
  end

  // Read word assembled from pre-edge state, so a same-cycle write is not seen.
  always_comb begin
    read_word = '0;
    if (maintREAD) begin
      read_word[18]          = maintBUSY;
      read_word[19]          = pending;
      read_word[FIELD_LO:34] = regCTRL;
    end
  end

  // Registered bus output: one cycle of read latency, zero when not read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busDATAO <= '0;
    end else begin
      busDATAO <= read_word;
    end
  end

endmodule

// File: tb/tb_uba_maint_ctl.sv
// Testbench for uba_maint_ctl: two instances (16/4 and 1/0 timing), an
// interval-based reference model, a per-cycle compare process and directed
// scenarios with hand-computed literal expectations.
module tb_uba_maint_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [0:35] din   [2];
  logic        wr    [2];
  logic        rd    [2];
  logic [0:35] dout  [2];
  logic [7:0]  ctrl  [2];
  logic        pulse [2];
  logic        busy  [2];
  logic        done  [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uba_maint_ctl #(.CTRL_WIDTH(8), .PULSE_LEN(16), .HOLDOFF_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .busDATAI(din[0]), .maintWRITE(wr[0]), .maintREAD(rd[0]),
    .busDATAO(dout[0]), .regCTRL(ctrl[0]), .maintPULSE(pulse[0]), .maintBUSY(busy[0]),
    .maintDONE(done[0])
  );

  uba_maint_ctl #(.CTRL_WIDTH(8), .PULSE_LEN(1), .HOLDOFF_LEN(0)) dut_b (
    .clk(clk), .rst(rst), .busDATAI(din[1]), .maintWRITE(wr[1]), .maintREAD(rd[1]),
    .busDATAO(dout[1]), .regCTRL(ctrl[1]), .maintPULSE(pulse[1]), .maintBUSY(busy[1]),
    .maintDONE(done[1])
  );

  function automatic int plen(input int i);
    return (i == 0) ? 16 : 1;
  endfunction

  function automatic int hlen(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic bit in_range(input int e, input int lo, input int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a sequence started at clock edge s is busy after edges
  // s..s+P+H-1, pulses after edges s..s+P-1 and strobes DONE after edge s+P+H.
  int          edge_n;
  int          m_start [2];
  bit          m_pend  [2];
  logic [7:0]  m_ctrl  [2];
  logic [0:35] m_dout  [2];

  initial begin
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      m_start[i] = -100000;
      m_pend[i]  = 1'b0;
      m_ctrl[i]  = '0;
      m_dout[i]  = '0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        edge_n = 0;
        for (int i = 0; i < 2; i++) begin
          m_start[i] = -100000;
          m_pend[i]  = 1'b0;
          m_ctrl[i]  = '0;
          m_dout[i]  = '0;
        end
      end else begin
        edge_n = edge_n + 1;
        for (int i = 0; i < 2; i++) begin
          bit was_busy;
          bit trig;
          was_busy = in_range(edge_n - 1, m_start[i], m_start[i] + plen(i) + hlen(i) - 1);
          trig     = wr[i] && din[i][35];
          m_dout[i] = '0;
          if (rd[i]) begin
            m_dout[i][18]    = was_busy;
            m_dout[i][19]    = m_pend[i];
            m_dout[i][27:34] = m_ctrl[i];
          end
          if (!was_busy && (trig || m_pend[i])) begin
            m_start[i] = edge_n;
            m_pend[i]  = 1'b0;
          end else if (was_busy && trig) begin
            m_pend[i] = 1'b1;
          end
          if (wr[i]) m_ctrl[i] = din[i][27:34];
        end
      end
    end
  end

  // Compare process: every output of both instances on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          int s;
          s = m_start[i];
          check($sformatf("pulse[%0d]", i), 64'(pulse[i]), 64'(in_range(edge_n, s, s + plen(i) - 1)));
          check($sformatf("busy[%0d]", i),  64'(busy[i]),  64'(in_range(edge_n, s, s + plen(i) + hlen(i) - 1)));
          check($sformatf("done[%0d]", i),  64'(done[i]),  64'(edge_n == s + plen(i) + hlen(i)));
          check($sformatf("ctrl[%0d]", i),  64'(ctrl[i]),  64'(m_ctrl[i]));
          check($sformatf("dout[%0d]", i),  64'(dout[i]),  64'(m_dout[i]));
        end
      end
    end
  end

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      wr[i]  = 1'b0;
      rd[i]  = 1'b0;
      din[i] = '0;
    end
  endtask

  task automatic set_write(input int i, input logic [7:0] field, input logic cr);
    din[i]        = '0;
    din[i][27:34] = field;
    din[i][35]    = cr;
    wr[i]         = 1'b1;
  endtask

  // Directed stimulus; inputs change on falling edges only.
  initial begin
    int pc, bc, dc, done_at, rises, first_done, second_rise;
    logic [0:35] hold_read;
    logic [15:0] pmap, dmap, bmap;
    clear_inputs();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_dout_a",  64'(dout[0]),  64'h0);
    check("rst_ctrl_a",  64'(ctrl[0]),  64'h0);
    check("rst_pulse_a", 64'(pulse[0]), 64'h0);
    check("rst_busy_a",  64'(busy[0]),  64'h0);
    check("rst_done_a",  64'(done[0]),  64'h0);
    rd[0] = 1'b1;
    @(negedge clk);
    clear_inputs();
    check("rst_read_a", 64'(dout[0]), 64'h0);

    // Plain write with junk outside the field, CR=0
    din[0]        = '1;
    din[0][27:34] = 8'hA5;
    din[0][35]    = 1'b0;
    wr[0]         = 1'b1;
    @(negedge clk);
    clear_inputs();
    check("wr_ctrl_a5", 64'(ctrl[0]),  64'hA5);
    check("wr_nopulse", 64'(pulse[0]), 64'h0);

    // Simultaneous read and write: read shows the old field
    set_write(0, 8'h3C, 1'b0);
    rd[0] = 1'b1;
    @(negedge clk);
    clear_inputs();
    check("rw_old_data", 64'(dout[0]), 64'h14A);
    check("rw_new_ctrl", 64'(ctrl[0]), 64'h3C);
    rd[0] = 1'b1;
    @(negedge clk);
    clear_inputs();
    check("read_3c", 64'(dout[0]), 64'h078);

    // Single CR trigger from IDLE
    pc = 0; bc = 0; dc = 0; done_at = -1;
    hold_read = '0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0) set_write(0, 8'h3C, 1'b1);
      if (k == 4) rd[0] = 1'b1;
      @(negedge clk);
      clear_inputs();
      if (pulse[0]) pc++;
      if (busy[0]) bc++;
      if (done[0]) begin dc++; done_at = k + 1; end
      if (k == 4) hold_read = dout[0];
    end
    check("one_pulse_len",  64'(pc), 64'd16);
    check("one_busy_len",   64'(bc), 64'd20);
    check("one_done_cnt",   64'(dc), 64'd1);
    check("one_done_at",    64'(done_at), 64'd21);
    check("one_busy_read",  64'(hold_read), 64'h20078);
    check("one_ctrl_kept",  64'(ctrl[0]), 64'h3C);

    // Queued triggers: one in PULSE, one in HOLD (dropped)
    pc = 0; dc = 0; rises = 0; first_done = -1; second_rise = -1;
    hold_read = '0;
    for (int k = 0; k < 60; k++) begin
      logic prev;
      prev = pulse[0];
      if (k == 0 || k == 6 || k == 19) set_write(0, 8'h3C, 1'b1);
      if (k == 17) rd[0] = 1'b1;
      @(negedge clk);
      clear_inputs();
      if (pulse[0]) pc++;
      if (pulse[0] && !prev) begin
        rises++;
        if (rises == 2) second_rise = k + 1;
      end
      if (done[0]) begin
        dc++;
        if (dc == 1) first_done = k + 1;
      end
      if (k == 17) hold_read = dout[0];
    end
    check("q_pulse_total", 64'(pc), 64'd32);
    check("q_rises",       64'(rises), 64'd2);
    check("q_dones",       64'(dc), 64'd2);
    check("q_first_done",  64'(first_done), 64'd21);
    check("q_second_rise", 64'(second_rise), 64'd22);
    check("q_hold_read",   64'(hold_read), 64'h30078);

    // Short build: 1-cycle pulse, no holdoff, back-to-back queued trigger
    pmap = '0; dmap = '0; bmap = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 0 || k == 1) set_write(1, 8'h01, 1'b1);
      @(negedge clk);
      clear_inputs();
      pmap[k+1] = pulse[1];
      dmap[k+1] = done[1];
      bmap[k+1] = busy[1];
    end
    check("b_pulse_map", 64'(pmap), 64'h000A);
    check("b_done_map",  64'(dmap), 64'h0014);
    check("b_busy_map",  64'(bmap), 64'h000A);
    check("b_ctrl",      64'(ctrl[1]), 64'h01);

    // Asynchronous reset in the middle of a pulse
    for (int k = 0; k < 5; k++) begin
      if (k == 0) set_write(0, 8'h3C, 1'b1);
      @(negedge clk);
      clear_inputs();
    end
    check("ar_pulse_before", 64'(pulse[0]), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("ar_pulse_dropped", 64'(pulse[0]), 64'h0);
    check("ar_busy_dropped",  64'(busy[0]),  64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dc = 0; pc = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done[0]) dc++;
      if (pulse[0]) pc++;
    end
    check("ar_no_done",  64'(dc), 64'd0);
    check("ar_no_pulse", 64'(pc), 64'd0);
    rd[0] = 1'b1;
    @(negedge clk);
    clear_inputs();
    check("ar_read_zero", 64'(dout[0]), 64'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uba_maint_ctl.md
# uba_maint_ctl

Parametrised UBA maintenance/control register that succeeds the single-bit maintenance register. It holds CTRL_WIDTH read/write control bits. It implements the Change Register (CR) bit as a timed one-shot sequencer with a holdoff interval and a one-deep pending queue. It provides registered read-back onto the backplane bus. It sits in the UBA register decode path, driven by the UBA's decoded maintenance read/write strobes.

## Interface
Parameters:
- CTRL_WIDTH, 8: number of R/W control bits, range 1..15, mapped to busDATAI/busDATAO bits [35-CTRL_WIDTH : 34].
- PULSE_LEN, 16: cycles maintPULSE is asserted per CR trigger, range 1..65535.
- HOLDOFF_LEN, 4: idle cycles enforced after each pulse, range 0..65535.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- busDATAI, input, [0:35]: backplane bus data in.
- maintWRITE, input, 1: write strobe, one cycle per access.
- maintREAD, input, 1: read strobe, one cycle per access.
- busDATAO, output, [0:35]: registered read data; zero when not responding.
- regCTRL, output, [CTRL_WIDTH-1:0]: current control bits. regCTRL[0] corresponds to bus bit 34.
- maintPULSE, output, 1: CR one-shot output.
- maintBUSY, output, 1: sequencer is not IDLE.
- maintDONE, output, 1: single-cycle strobe when a sequence completes.

## Operation
- Reset value of every output is 0. Internal state also resets: state=IDLE, counter=0, pending=0.
- Write (maintWRITE=1):
  - regCTRL is loaded from busDATAI[35-CTRL_WIDTH:34].
  - busDATAI[35] (CR) is a trigger only and is never stored.
  - Bits outside the control field and CR are ignored.
- Sequencer states:
  - IDLE: if a CR trigger or pending is set, go to PULSE, load counter=PULSE_LEN-1, and clear pending.
  - PULSE: maintPULSE=1. While the counter is nonzero, decrement it. At 0, go to HOLD and load counter=HOLDOFF_LEN-1; if HOLDOFF_LEN=0, go to IDLE instead and assert DONE.
  - HOLD: maintPULSE=0. While the counter is nonzero, decrement it. At 0, go to IDLE and assert DONE.
- A CR trigger while in PULSE or HOLD sets pending. Further triggers while pending=1 are dropped; the queue is one deep.
- If pending=1 on entry to IDLE, the next PULSE starts on the following cycle. DONE still strobes for the completed sequence.
- A write with CR=0 never affects the sequencer.
- Read (maintREAD=1): on the next cycle, busDATAO carries the following fields, with all other bits 0:
  - bit 18: maintBUSY
  - bit 19: pending
  - bits [35-CTRL_WIDTH:34]: regCTRL
  - bit 35: always 0 (CR reads as 0)
- busDATAO returns to 0 on the cycle after any cycle where maintREAD=0.
- Simultaneous read and write in one cycle: read data reflects the pre-write regCTRL, BUSY and pending.
- Reset mid-sequence: the asynchronous clear drops maintPULSE, BUSY and pending immediately. No DONE is issued.

## Timing
- Trigger in IDLE at edge N: maintPULSE and maintBUSY are high for exactly cycles N+1..N+PULSE_LEN.
- HOLD then occupies cycles N+PULSE_LEN+1..N+PULSE_LEN+HOLDOFF_LEN.
- DONE is high during cycle N+PULSE_LEN+HOLDOFF_LEN+1, together with BUSY=0 that cycle.
- If HOLDOFF_LEN=0, DONE is high during cycle N+PULSE_LEN+1.
- Queued trigger: the second pulse begins 1 cycle after DONE. There is therefore at least one IDLE cycle between sequences.
- Read latency is 1 cycle. regCTRL updates 1 cycle after maintWRITE.
- The counter is 16 bits wide. The terminal count is compared to 0, so the counter never wraps.

## Test plan
- Reset: hold rst, then release -> all outputs are 0. Read gives busDATAO=0.
- Write with ctrl field=8'hA5 and CR=0, then read -> regCTRL=8'hA5, bits 27..34 of busDATAO=A5, bit 35=0, no pulse.
- CR write in IDLE with PULSE_LEN=16 and HOLDOFF_LEN=4 -> maintPULSE high for exactly 16 cycles, BUSY high for 20 cycles, one DONE on the 21st cycle.
- CR write during PULSE, and another during HOLD -> exactly two pulses total; pending bit 19 reads 1 during HOLD; second pulse starts 1 cycle after the first DONE.
- Build with HOLDOFF_LEN=0 and PULSE_LEN=1 -> 1-cycle pulse, DONE on the next cycle; back-to-back queued trigger separated by one IDLE cycle.
- Assert rst asynchronously mid-PULSE, off a clock edge -> maintPULSE drops before the next clk edge; no DONE; a read after reset shows 0.
